// File: rtl/pipe_chain.sv
// -----------------------------------------------------------------------------
// pipe_chain
//   Elastic pipeline-register chain of DEPTH stages, each WIDTH bits wide.
//   Every stage carries a valid bit. A combinational ready chain lets items
//   advance into empty (or flushed) stages even while the output is stalled,
//   so bubbles collapse. A per-stage flush mask kills the item held in a stage
//   before it can be forwarded or output.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   in_valid   upstream presents in_data
//   in_ready   stage 0 accepts this cycle
//   in_data    upstream payload
//   out_valid  last stage holds a live item
//   out_ready  downstream accepts this cycle
//   out_data   payload of the last stage
//   flush      bit i kills the item currently held in stage i
//   occupancy  count of valid stages as registered (flush not applied)
//   stall_cnt  saturating count of output-stall edges
//              (present only when PIPE_STALL_CNT_EN is defined)
//
// Configuration macro
//   PIPE_STALL_CNT_EN  adds the stall_cnt port and its saturating counter.
// -----------------------------------------------------------------------------
module pipe_chain #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic [DEPTH-1:0] flush,
    output logic [OCC_W-1:0] occupancy
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    // Reject nonsensical parameterisations at elaboration time.
    if (WIDTH < 1 || DEPTH < 1 || CNT_W < 1) begin : g_paramCheck
        $error("pipe_chain: WIDTH, DEPTH and CNT_W must all be >= 1");
    end

    logic [DEPTH-1:0] r_valid;
    logic [WIDTH-1:0] r_data [DEPTH];

    logic [DEPTH-1:0] w_live;
    logic [DEPTH:0]   w_rdy;
    logic [DEPTH-1:0] w_srcValid;
    logic [WIDTH-1:0] w_srcData [DEPTH];
    logic [OCC_W-1:0] w_occ;

    // A flushed stage counts as empty: it never holds back the stage before it
    // and never passes its item on.
    assign w_live = r_valid & ~flush;

    // Ready ripples from the output back towards the input: a stage can take
    // a new item if it is empty/killed or if its own item is moving on.
    always_comb begin
        w_rdy        = '0;
        w_rdy[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_rdy[i] = ~w_live[i] | w_rdy[i+1];
        end
    end

    // Each stage is fed by its predecessor (or the input port for stage 0).
    always_comb begin
        w_srcValid[0] = in_valid;
        w_srcData[0]  = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            w_srcValid[i] = w_live[i-1];
            w_srcData[i]  = r_data[i-1];
        end
    end

    // Stage registers: a ready stage takes its source's valid bit and loads
    // data only for a real item, so idle payload stays put.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_rdy[i]) begin
                    r_valid[i] <= w_srcValid[i];
                    if (w_srcValid[i]) begin
                        r_data[i] <= w_srcData[i];
                    end
                end
            end
        end
    end

    // Occupancy is a popcount of the registered valid bits, so it reflects
    // the state left by the last edge regardless of the current flush mask.
    always_comb begin
        w_occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occ = w_occ + OCC_W'(r_valid[i]);
        end
    end

    assign occupancy = w_occ;
    assign in_ready  = w_rdy[0];
    assign out_valid = w_live[DEPTH-1];
    assign out_data  = r_data[DEPTH-1];

`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] r_stallCnt;

    // Count edges where a live item sits at the output but is refused;
    // hold at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stallCnt <= '0;
        end else if (out_valid && !out_ready && (r_stallCnt != '1)) begin
            r_stallCnt <= r_stallCnt + 1'b1;
        end
    end

    assign stall_cnt = r_stallCnt;
`endif

endmodule

// File: tb/tb_pipe_chain.sv
// -----------------------------------------------------------------------------
// tb_pipe_chain
//   Directed test of pipe_chain with DEPTH=4, WIDTH=8, CNT_W=3. Inputs change
//   1 time unit after a rising edge; outputs are compared after a further
//   settle delay, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_pipe_chain;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [DEPTH-1:0] flush;
    logic [OCC_W-1:0] occupancy;
`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
`endif

    int checkCount;
    int passCount;

    pipe_chain #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .flush    (flush),
        .occupancy(occupancy)
`ifdef PIPE_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d,
                                 input logic ordy, input logic [DEPTH-1:0] fl);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    // Advance one rising edge and step just past it.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        rst = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b1, 4'b0000);
        #2;

        // Reset state
        checkOutput("rst out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst out_data",  32'(out_data),  32'h00);
        checkOutput("rst occupancy", 32'(occupancy), 32'd0);
        checkOutput("rst in_ready",  32'(in_ready),  32'd1);
`ifdef PIPE_STALL_CNT_EN
        checkOutput("rst stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        #1 rst = 1'b0;
        tick;

        // 1: latency and back-to-back throughput
        applyStimulus(1'b1, 8'h11, 1'b1, 4'b0000);
        tick;
        applyStimulus(1'b1, 8'h22, 1'b1, 4'b0000);
        tick;
        applyStimulus(1'b1, 8'h33, 1'b1, 4'b0000);
        tick;
        checkOutput("t1 not yet valid", 32'(out_valid), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b1, 4'b0000);
        tick;
        checkOutput("t1 out0 valid", 32'(out_valid), 32'd1);
        checkOutput("t1 out0 data",  32'(out_data),  32'h11);
        tick;
        checkOutput("t1 out1 valid", 32'(out_valid), 32'd1);
        checkOutput("t1 out1 data",  32'(out_data),  32'h22);
        tick;
        checkOutput("t1 out2 valid", 32'(out_valid), 32'd1);
        checkOutput("t1 out2 data",  32'(out_data),  32'h33);
        tick;
        checkOutput("t1 drained", 32'(out_valid), 32'd0);
        checkOutput("t1 occ 0",   32'(occupancy), 32'd0);

        // 2: fill against a stalled output, then drain with concurrent pushes
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(1'b1, WIDTH'(k), 1'b0, 4'b0000);
            #1;
            checkOutput($sformatf("t2 in_ready push%0d", k), 32'(in_ready),
                        (k <= 4) ? 32'd1 : 32'd0);
            tick;
        end
        checkOutput("t2 occ full", 32'(occupancy), 32'd4);
        for (int c = 0; c < 6; c++) begin
            applyStimulus((c < 2), WIDTH'(5 + c), 1'b1, 4'b0000);
            #1;
            if (c == 0) begin
                checkOutput("t2 full+drain in_ready", 32'(in_ready), 32'd1);
            end
            checkOutput($sformatf("t2 drain%0d valid", c), 32'(out_valid), 32'd1);
            checkOutput($sformatf("t2 drain%0d data", c),  32'(out_data),  32'(c + 1));
            tick;
            if (c == 0) begin
                checkOutput("t2 occ after pop+push", 32'(occupancy), 32'd4);
            end
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 4'b0000);
        #1;
        checkOutput("t2 empty", 32'(out_valid), 32'd0);
        checkOutput("t2 occ 0", 32'(occupancy), 32'd0);

        // 3: only stage 3 valid while stalled, bubbles collapse behind it
        applyStimulus(1'b1, 8'hDD, 1'b0, 4'b0000);
        tick;
        applyStimulus(1'b0, 8'h00, 1'b0, 4'b0000);
        tick;
        tick;
        tick;
        checkOutput("t3 stage3 valid", 32'(out_valid), 32'd1);
        checkOutput("t3 occ 1",        32'(occupancy), 32'd1);
        checkOutput("t3 in_ready",     32'(in_ready),  32'd1);
        applyStimulus(1'b1, 8'hCC, 1'b0, 4'b0000);
        #1 checkOutput("t3 rdy C", 32'(in_ready), 32'd1);
        tick;
        applyStimulus(1'b1, 8'hBB, 1'b0, 4'b0000);
        #1 checkOutput("t3 rdy B", 32'(in_ready), 32'd1);
        tick;
        applyStimulus(1'b1, 8'hAA, 1'b0, 4'b0000);
        #1 checkOutput("t3 rdy A", 32'(in_ready), 32'd1);
        tick;
        applyStimulus(1'b0, 8'h00, 1'b0, 4'b0000);
        #1;
        checkOutput("t3 full in_ready", 32'(in_ready),  32'd0);
        checkOutput("t3 occ 4",         32'(occupancy), 32'd4);

        // 4: stages hold A,B,C,D (0..3); kill A and B while D leaves
        applyStimulus(1'b0, 8'h00, 1'b1, 4'b0011);
        #1;
        checkOutput("t4 out D",        32'(out_data),  32'hDD);
        checkOutput("t4 occ preflush", 32'(occupancy), 32'd4);
        checkOutput("t4 in_ready",     32'(in_ready),  32'd1);
        tick;
        applyStimulus(1'b0, 8'h00, 1'b1, 4'b0000);
        #1;
        checkOutput("t4 out C valid", 32'(out_valid), 32'd1);
        checkOutput("t4 out C data",  32'(out_data),  32'hCC);
        checkOutput("t4 occ only C",  32'(occupancy), 32'd1);
        for (int c = 0; c < 4; c++) begin
            tick;
            checkOutput($sformatf("t4 no A/B %0d", c), 32'(out_valid), 32'd0);
        end
        checkOutput("t4 occ 0", 32'(occupancy), 32'd0);

        // 5: asynchronous reset between edges, then normal operation
        applyStimulus(1'b1, 8'h77, 1'b0, 4'b0000);
        tick;
        applyStimulus(1'b1, 8'h78, 1'b0, 4'b0000);
        tick;
        applyStimulus(1'b0, 8'h00, 1'b0, 4'b0000);
        tick;
        tick;
        checkOutput("t5 pre-rst valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("t5 rst out_valid", 32'(out_valid), 32'd0);
        checkOutput("t5 rst occupancy", 32'(occupancy), 32'd0);
        checkOutput("t5 rst in_ready",  32'(in_ready),  32'd1);
        checkOutput("t5 rst out_data",  32'(out_data),  32'h00);
        #1 rst = 1'b0;
        tick;
        applyStimulus(1'b1, 8'h5A, 1'b1, 4'b0000);
        tick;
        applyStimulus(1'b0, 8'h00, 1'b1, 4'b0000);
        tick;
        tick;
        checkOutput("t5 not yet", 32'(out_valid), 32'd0);
        tick;
        checkOutput("t5 5A valid", 32'(out_valid), 32'd1);
        checkOutput("t5 5A data",  32'(out_data),  32'h5A);
        tick;
        checkOutput("t5 drained", 32'(out_valid), 32'd0);

`ifdef PIPE_STALL_CNT_EN
        // 6: stall counter counts refused edges and saturates
        rst = 1'b1;
        #1 rst = 1'b0;
        checkOutput("t6 cnt cleared", 32'(stall_cnt), 32'd0);
        applyStimulus(1'b1, 8'h66, 1'b0, 4'b0000);
        tick;
        applyStimulus(1'b0, 8'h00, 1'b0, 4'b0000);
        tick;
        tick;
        tick;
        checkOutput("t6 out_valid", 32'(out_valid), 32'd1);
        checkOutput("t6 cnt 0",     32'(stall_cnt), 32'd0);
        for (int c = 0; c < 5; c++) tick;
        checkOutput("t6 cnt 5", 32'(stall_cnt), 32'd5);
        for (int c = 0; c < 5; c++) tick;
        checkOutput("t6 cnt sat", 32'(stall_cnt), 32'd7);
        applyStimulus(1'b0, 8'h00, 1'b1, 4'b0000);
        tick;
        tick;
        checkOutput("t6 cnt held", 32'(stall_cnt), 32'd7);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
